// File: rtl/car_counter_pkg.sv
// Shared constants and types for the parking-lot occupancy counter.
package car_counter_pkg;

  // Default counter width and saturation ceiling.
  localparam int COUNT_W_DEF   = 3;
  localparam int MAX_COUNT_DEF = (1 << COUNT_W_DEF) - 1;

  // Per-cycle update decision for the occupancy counter.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } upd_e;

endpackage

// File: rtl/car_counter_edge_det.sv
// Rising-edge detector for one gate sensor.
// Optional 2-flop synchronizer enabled by the CAR_COUNTER_SYNC_EN macro.
module car_counter_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic cur;     // sensor level as seen by the edge detector
  logic prev_d;
  logic prev_q;

`ifdef CAR_COUNTER_SYNC_EN
  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  // Synchronizer next-state: shift the raw level through two stages.
  always_comb begin
    sync1_d = sig_i;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared on reset so a held sensor reads as a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // which is what makes the two stages a real shift chain.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign cur = sync2_q;
`else
  // Inputs are already synchronous to clk; edge-detect the raw level.
  assign cur = sig_i;
`endif

  // Previous-level next-state: track the detector's current level.
  always_comb begin
    prev_d = cur;
  end

  // Previous-level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  // One-cycle pulse per 0->1 transition.
  assign rise_o = cur & ~prev_q;

endmodule

// File: rtl/car_counter.sv
// Parking-lot occupancy counter: saturating count of cars inside.
// Define CAR_COUNTER_SYNC_EN to add a 2-flop synchronizer on each sensor.
module car_counter
  import car_counter_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int MAX_COUNT = (1 << COUNT_W) - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carIn,
  input  logic               carOut,
  output logic [COUNT_W-1:0] counter
);

  localparam logic [COUNT_W-1:0] MAX_V = COUNT_W'(MAX_COUNT);

  logic               in_p;
  logic               out_p;
  upd_e               upd;
  logic [COUNT_W-1:0] counter_d;
  logic [COUNT_W-1:0] counter_q;

  car_counter_edge_det u_in_det (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (carIn),
    .rise_o (in_p)
  );

  car_counter_edge_det u_out_det (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (carOut),
    .rise_o (out_p)
  );

  // Decide the counter update; saturation turns a blocked step into HOLD.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives upd,
    // so no latch is inferred.
    upd = HOLD;
    if (in_p && !out_p && (counter_q < MAX_V)) upd = INC;
    else if (out_p && !in_p && (counter_q != '0)) upd = DEC;
  end

  // Apply the decision to form the next count.
  always_comb begin
    counter_d = counter_q;
    unique case (upd)
      INC:     counter_d = counter_q + 1'b1;
      DEC:     counter_d = counter_q - 1'b1;
      default: counter_d = counter_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) counter_q <= '0;
    else       counter_q <= counter_d;
  end

  assign counter = counter_q;

endmodule

// File: tb/tb_car_counter.sv
// Self-checking directed bench for car_counter (default and synchronized builds).
module tb_car_counter;

`ifdef CAR_COUNTER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       carIn;
  logic       carOut;
  logic [2:0] counter;

  int n_tests  = 0;
  int n_failed = 0;

  car_counter dut (
    .clk     (clk),
    .reset   (reset),
    .carIn   (carIn),
    .carOut  (carOut),
    .counter (counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One sensor pulse: 20 cycles high, 20 low, driven on falling edges.
  task automatic pulse(input logic i, input logic o);
    @(negedge clk);
    carIn  = i;
    carOut = o;
    repeat (20) @(negedge clk);
    carIn  = 1'b0;
    carOut = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    carIn  = 1'b0;
    carOut = 1'b0;

    // 1. Reset held 5 cycles
    repeat (3) @(negedge clk);
    check("reset_during", counter, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_after", counter, 0);

    // 2. Eight entry pulses, saturating at 7
    for (int k = 1; k <= 8; k++) begin
      pulse(1'b1, 1'b0);
      check($sformatf("in_pulse_%0d", k), counter, (k > 7) ? 7 : k);
    end

    // 3. Eight exit pulses, floor at 0
    for (int k = 1; k <= 8; k++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("out_pulse_%0d", k), counter, (k > 7) ? 0 : 7 - k);
    end

    // 4. Simultaneous events cancel, at 0 and at 3
    pulse(1'b1, 1'b1);
    check("both_at_0", counter, 0);
    for (int k = 1; k <= 3; k++) pulse(1'b1, 1'b0);
    check("climb_to_3", counter, 3);
    pulse(1'b1, 1'b1);
    check("both_at_3", counter, 3);

    // 5. Async reset mid-carIn-pulse at 5
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("climb_to_5", counter, 5);
    @(negedge clk);
    carIn = 1'b1;
    #2;
    check("pre_reset_5", counter, 5);
    reset = 1'b1;
    #1;
    check("async_reset_clear", counter, 0);
    repeat (3) @(negedge clk);
    check("reset_hold_clear", counter, 0);
    reset = 1'b0;
    // Latency with carIn held high through deassertion
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_rise_edge_%0d", k), counter, (k < LAT) ? 0 : 1);
    end
    repeat (10) @(negedge clk);
    check("held_counts_once", counter, 1);
    carIn = 1'b0;
    repeat (10) @(negedge clk);

    // 6. Latency of an entry and an exit event
    @(negedge clk);
    carIn = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_in_edge_%0d", k), counter, (k < LAT) ? 1 : 2);
    end
    @(negedge clk);
    carIn = 1'b0;
    repeat (5) @(negedge clk);
    carOut = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_out_edge_%0d", k), counter, (k < LAT) ? 2 : 1);
    end
    @(negedge clk);
    carOut = 1'b0;
    repeat (5) @(negedge clk);
    check("final", counter, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
